multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback around the existing decoder/ALU/register-file datapath.
- Arbitrates instruction and data memory accesses through req/ack handshakes.
- Gates the register-file and PC write enables, and keeps retirement and cycle counters.

Parameters:
COUNTER_BITS, 32, width of cycle_count and instret_count
TIMEOUT_CYCLES, 255, maximum number of cycles a memory req may stay unacknowledged (only used with MEM_TIMEOUT_EN)

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
opcode  in  7  instruction[6:0] from the decoder
dec_wEn  in  1  decoder register-file write enable
dec_mem_wEn  in  1  decoder store indication
branch_op  in  1  decoder branch flag
branch_taken  in  1  ALU branch comparison result
imem_ack  in  1  instruction memory acknowledge
dmem_ack  in  1  data memory acknowledge
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write strobe
ir_load  out  1  capture the fetched instruction
operand_load  out  1  latch register-file read data and imm32
rf_wEn  out  1  gated register-file write enable
pc_write  out  1  PC update strobe
pc_sel  out  2  PC source: 00 PC+4, 01 PC+imm (taken branch / JAL), 10 rs1+imm (JALR)
halted  out  1  sticky, set on SYSTEM opcode 1110011
illegal_instr  out  1  sticky, set on an unrecognised opcode
bus_fault  out  1  sticky, set on memory timeout (0 when the feature is compiled out)
cycle_count  out  COUNTER_BITS  cycles spent outside HALT/TRAP
instret_count  out  COUNTER_BITS  retired instructions

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- Reset (async, reset_n=0):
  - state=FETCH; counters=0; sticky flags=0.
  - All strobes are 0 while reset_n is asserted.
  - Reset mid-access abandons any outstanding req; the first cycle after release issues imem_req.
- FETCH:
  - imem_req=1.
  - While imem_ack=1: ir_load=1 in the same cycle (Mealy), next state DECODE.
  - imem_ack=0: stay in FETCH with req held.
- DECODE:
  - operand_load=1.
  - SYSTEM opcode -> HALT.
  - Opcode not one of R/I/LOAD/S/B/JAL/JALR/AUIPC/LUI -> TRAP.
  - Otherwise -> EXECUTE.
- EXECUTE: one cycle. LOAD or S_TYPE -> MEM; all other opcodes -> WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=dec_mem_wEn.
  - On dmem_ack, store: pc_write=1, pc_sel=00, instret increments, next state FETCH.
  - On dmem_ack, load: next state WRITEBACK.
- WRITEBACK:
  - rf_wEn=dec_wEn; pc_write=1; instret increments; next state FETCH.
  - pc_sel:
    - 01 for JAL, or for B_TYPE with branch_taken=1.
    - 10 for JALR.
    - 00 otherwise, including a not-taken branch.
- Strobe exclusivity: rf_wEn and pc_write are never asserted outside WRITEBACK, except the store pc_write in MEM. dmem_we=0 whenever dmem_req=0.
- Handshake rules:
  - A req stays asserted until its ack is sampled high, then drops the next cycle.
  - An ack seen while req=0 is ignored.
  - imem_req and dmem_req are never high in the same cycle.
- Latency (zero-wait memory):
  - ALU, branch, jump, AUIPC, LUI: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- HALT / TRAP:
  - Terminal until reset; all strobes 0.
  - halted or illegal_instr is asserted from the cycle after entry.
- Counters:
  - cycle_count increments on every cycle not in HALT/TRAP.
  - Both counters wrap modulo 2^COUNTER_BITS with no flag.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter is cleared on req rise and increments each cycle with req=1 and ack=0.
  - When it reaches TIMEOUT_CYCLES: bus_fault=1, state goes to TRAP, req drops the next cycle.
- Undefined:
  - No wait counter; the FSM waits indefinitely.
  - bus_fault is tied to 0.

Decomposition:
- Shared package / defines include:
  - Opcode constants (existing R_TYPE..U_LUI, plus SYSTEM).
  - State encoding (3-bit).
  - pc_sel encodings PC_PLUS4, PC_REL, PC_JALR.
- One sub-module: seq_perf_counters, holding cycle_count and instret_count, with inputs count_en and retire.

Test Plan:
- ADDI, zero-wait acks -> imem_req at cycle 1; rf_wEn=1 and pc_write=1 with pc_sel=00 at cycle 4; instret_count=1.
- LW with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; rf_wEn at cycle 8.
- BEQ with branch_taken=1, then with branch_taken=0 -> pc_sel=01 then 00; rf_wEn stays 0 in both cases.
- SW -> dmem_we=1 with dmem_req; pc_write in the ack cycle; no WRITEBACK state visited; rf_wEn never 1.
- Opcode 0x7F, then a separate run with ECALL (0x73) -> illegal_instr=1 and halted=1 respectively; strobes 0 and cycle_count frozen afterwards.
- reset_n pulsed low while dmem_req is pending -> all outputs 0 immediately; after release, FETCH restarts with counters=0. With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, withholding imem_ack gives bus_fault=1 after 4 wait cycles.

Source files
------------

// File: rtl/multicycle_sequencer_pkg.sv
// multicycle_sequencer_pkg: shared opcode constants, FSM state encoding and
// PC-source encodings for the multicycle RV32I control sequencer.
package multicycle_sequencer_pkg;

  // RV32I major opcodes (instruction[6:0])
  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_TYPE  = 7'b0010011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] U_AUIPC = 7'b0010111;
  localparam logic [6:0] U_LUI   = 7'b0110111;
  localparam logic [6:0] SYSTEM  = 7'b1110011;

  // PC source select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    TRAP      = 3'd6
  } state_e;

  // True for every opcode the core can execute (SYSTEM is handled separately)
  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      R_TYPE, I_TYPE, LOAD, S_TYPE, B_TYPE,
      JAL, JALR, U_AUIPC, U_LUI: is_known_opcode = 1'b1;
      default:                   is_known_opcode = 1'b0;
    endcase
  endfunction

  // True for opcodes that need a data-memory access
  function automatic logic is_mem_opcode(input logic [6:0] op);
    is_mem_opcode = (op == LOAD) || (op == S_TYPE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_perf.sv
// seq_perf_counters: free-running cycle counter and retired-instruction
// counter; both wrap silently at 2^COUNTER_BITS.
module seq_perf_counters #(
  parameter int COUNTER_BITS = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    count_en,
  input  logic                    retire,
  output logic [COUNTER_BITS-1:0] cycle_count,
  output logic [COUNTER_BITS-1:0] instret_count
);

  logic [COUNTER_BITS-1:0] cycle_q, cycle_d;
  logic [COUNTER_BITS-1:0] instret_q, instret_d;

  // Next-count logic: each counter advances by one when its enable is high
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (count_en) cycle_d   = cycle_q + COUNTER_BITS'(1);
    if (retire)   instret_d = instret_q + COUNTER_BITS'(1);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: control FSM for the multicycle RV32I core. Sequences
// fetch/decode/execute/mem/writeback, runs the imem/dmem req/ack handshakes,
// gates RF and PC writes and keeps perf counters.
// Optional memory-timeout watchdog: define MEM_TIMEOUT_EN.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int COUNTER_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [6:0]              opcode,
  input  logic                    dec_wEn,
  input  logic                    dec_mem_wEn,
  input  logic                    branch_op,
  input  logic                    branch_taken,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic                    ir_load,
  output logic                    operand_load,
  output logic                    rf_wEn,
  output logic                    pc_write,
  output logic [1:0]              pc_sel,
  output logic                    halted,
  output logic                    illegal_instr,
  output logic                    bus_fault,
  output logic [COUNTER_BITS-1:0] cycle_count,
  output logic [COUNTER_BITS-1:0] instret_count
);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   halted_q, halted_d;
  logic   illegal_q, illegal_d;
  logic   retire;
  logic   count_en;
  logic   timeout_fire;

  // run_q holds every strobe low from reset until the first clock edge after
  // release, so nothing is requested while reset_n is low.

  // Next-state and strobe decode; all strobes default low
  always_comb begin
    state_d      = state_q;
    run_d        = 1'b1;
    halted_d     = halted_q;
    illegal_d    = illegal_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_load      = 1'b0;
    operand_load = 1'b0;
    rf_wEn       = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = PC_PLUS4;
    retire       = 1'b0;
    case (state_q)
      FETCH: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        operand_load = 1'b1;
        if (opcode == SYSTEM) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (!is_known_opcode(opcode)) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = is_mem_opcode(opcode) ? MEM : WRITEBACK;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_wEn;
        if (dmem_ack) begin
          if (dec_mem_wEn) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        rf_wEn   = dec_wEn;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
        if (opcode == JALR) begin
          pc_sel = PC_JALR;
        end else if ((opcode == JAL) ||
                     ((opcode == B_TYPE) && branch_op && branch_taken)) begin
          pc_sel = PC_REL;
        end
      end
      HALT, TRAP: begin
        state_d = state_q;
      end
      default: begin
        state_d = TRAP;
      end
    endcase
    if (timeout_fire) state_d = TRAP;
  end

  // State and sticky-flag registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      run_q     <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign halted        = halted_q;
  assign illegal_instr = illegal_q;
  assign count_en      = run_q && (state_q != HALT) && (state_q != TRAP);

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                 bus_fault_q, bus_fault_d;
  logic                 req_waiting;
  logic                 timeout_hit;

  // Decoded from the state register, not the strobes, to keep the watchdog
  // out of the FSM's combinational path.
  assign req_waiting = ((state_q == FETCH) && run_q && !imem_ack) ||
                       ((state_q == MEM) && !dmem_ack);
  assign timeout_hit  = (wait_cnt_q == WAIT_BITS'(TIMEOUT_CYCLES - 1));
  assign timeout_fire = req_waiting && timeout_hit;

  // Wait counter restarts whenever no request is stalled
  always_comb begin
    wait_cnt_d  = '0;
    bus_fault_d = bus_fault_q || timeout_fire;
    if (req_waiting && !timeout_hit) wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
  end

  // Watchdog registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q  <= '0;
      bus_fault_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      bus_fault_q <= bus_fault_d;
    end
  end

  assign bus_fault = bus_fault_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_fire   = 1'b0;
  assign bus_fault      = 1'b0;
`endif

  seq_perf_counters #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_perf (
    .clock        (clock),
    .reset_n      (reset_n),
    .count_en     (count_en),
    .retire       (retire),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

endmodule
